// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID / uptime register block.
package sysid_pkg;

  // Word offsets within the 8-word register window.
  typedef enum logic [2:0] {
    REG_ID        = 3'd0,
    REG_TS        = 3'd1,
    REG_UPTIME_LO = 3'd2,
    REG_UPTIME_HI = 3'd3,
    REG_CTRL      = 3'd4,
    REG_PRESCALE  = 3'd5,
    REG_SCRATCH0  = 3'd6,
    REG_SCRATCH1  = 3'd7
  } reg_addr_e;

  // CTRL register bit positions.
  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_CLR = 1;

  // Width of the free-running uptime counter.
  localparam int unsigned UPTIME_W = 64;

endpackage

// File: rtl/sysid_uptime.sv
// Prescaled 64-bit uptime counter with a high-word snapshot taken on low-word reads.
module sysid_uptime
  import sysid_pkg::*;
#(
  parameter int unsigned         PRESCALE_W = 16,
  parameter logic [UPTIME_W-1:0] CNT_RST    = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  prescale_wr,
  input  logic                  snap,
  output logic [31:0]           count_lo,
  output logic [31:0]           snap_hi
);

  logic [PRESCALE_W-1:0] pscnt_q, pscnt_d;
  logic [UPTIME_W-1:0]   cnt_q,   cnt_d;
  logic [31:0]           snap_q,  snap_d;
  logic                  tick;

  // Next-state: prescaler wrap drives the counter tick; clear beats tick,
  // and the snapshot captures the pre-increment high word.
  always_comb begin
    tick    = en && (pscnt_q == prescale);
    pscnt_d = pscnt_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    if (en) begin
      pscnt_d = tick ? '0 : pscnt_q + PRESCALE_W'(1);
    end
    if (tick) begin
      cnt_d = cnt_q + UPTIME_W'(1);
    end
    if (clr || prescale_wr) begin
      pscnt_d = '0;
    end
    if (clr) begin
      cnt_d = '0;
    end
    if (snap) begin
      snap_d = cnt_q[UPTIME_W-1:32];
    end
  end

  // State registers for prescaler, counter and snapshot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pscnt_q <= '0;
      cnt_q   <= CNT_RST;
      snap_q  <= '0;
    end else begin
      pscnt_q <= pscnt_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
    end
  end

  assign count_lo = cnt_q[31:0];
  assign snap_hi  = snap_q;

endmodule

// File: rtl/sysid_regs.sv
// System-ID slave: ID/timestamp words, uptime counter, CTRL, PRESCALE and
// scratch registers behind an Avalon-MM slave with fixed read latency 1.
// UPTIME_RST presets the counter out of reset; leave at 0 for normal builds.
module sysid_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0]         SYSTEM_ID    = 32'h0000_0000,
  parameter logic [31:0]         TIMESTAMP    = 32'd0,
  parameter int unsigned         PRESCALE_W   = 16,
  parameter logic [31:0]         PRESCALE_RST = 32'd0,
  parameter logic [UPTIME_W-1:0] UPTIME_RST   = '0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  reg_addr_e             addr;
  logic                  rd_en, wr_en;
  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [31:0]           scratch0_q, scratch0_d;
  logic [31:0]           scratch1_q, scratch1_d;
  logic [31:0]           readdata_q, readdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  clr, prescale_wr, snap;
  logic [31:0]           count_lo, snap_hi;
  logic [31:0]           rdata, prescale_rd;

  assign addr  = reg_addr_e'(address);
  assign rd_en = chipselect & read;
  assign wr_en = chipselect & write;

  assign clr         = wr_en && (addr == REG_CTRL) && writedata[CTRL_CLR];
  assign prescale_wr = wr_en && (addr == REG_PRESCALE);
  assign snap        = rd_en && (addr == REG_UPTIME_LO);

  sysid_uptime #(
    .PRESCALE_W (PRESCALE_W),
    .CNT_RST    (UPTIME_RST)
  ) u_uptime (
    .clock       (clock),
    .reset_n     (reset_n),
    .en          (en_q),
    .clr         (clr),
    .prescale    (prescale_q),
    .prescale_wr (prescale_wr),
    .snap        (snap),
    .count_lo    (count_lo),
    .snap_hi     (snap_hi)
  );

  // Write decode for the RW registers; RO words ignore writes.
  always_comb begin
    en_d       = en_q;
    prescale_d = prescale_q;
    scratch0_d = scratch0_q;
    scratch1_d = scratch1_q;
    if (wr_en) begin
      case (addr)
        REG_CTRL:     en_d       = writedata[CTRL_EN];
        REG_PRESCALE: prescale_d = writedata[PRESCALE_W-1:0];
        REG_SCRATCH0: scratch0_d = writedata;
        REG_SCRATCH1: scratch1_d = writedata;
        default:      ;
      endcase
    end
  end

  // Read mux from current register values, so a same-cycle write reads old data.
  always_comb begin
    prescale_rd                 = '0;
    prescale_rd[PRESCALE_W-1:0] = prescale_q;
    rdata                       = '0;
    case (addr)
      REG_ID:        rdata = SYSTEM_ID;
      REG_TS:        rdata = TIMESTAMP;
      REG_UPTIME_LO: rdata = count_lo;
      REG_UPTIME_HI: rdata = snap_hi;
      REG_CTRL:      rdata[CTRL_EN] = en_q;
      REG_PRESCALE:  rdata = prescale_rd;
      REG_SCRATCH0:  rdata = scratch0_q;
      REG_SCRATCH1:  rdata = scratch1_q;
      default:       rdata = '0;
    endcase
    readdata_d = rd_en ? rdata : readdata_q;
    rvalid_d   = rd_en;
  end

  // Register state and the registered read response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en_q       <= 1'b1;
      prescale_q <= PRESCALE_RST[PRESCALE_W-1:0];
      scratch0_q <= '0;
      scratch1_q <= '0;
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      en_q       <= en_d;
      prescale_q <= prescale_d;
      scratch0_q <= scratch0_d;
      scratch1_q <= scratch1_d;
      readdata_q <= readdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;

endmodule
